// File: rtl/trivium_keygen.sv
// Trivium keystream generator feeding a byte FIFO.
// Loads key/IV, discards WARMUP rounds, then packs keystream into bytes.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        begin a run (sampled only while idle)
//   stop         abort the run on the next edge, from any state
//   key, iv      80-bit key and IV (K_i = key[i-1], IV_i = iv[i-1])
//   len          byte count to produce, 0 = run until stop
//   fifo_full    FIFO back-pressure
//   dout, write  keystream byte and FIFO write strobe
//   busy, done   run in progress / one-cycle completion pulse
module trivium_keygen #(
    parameter int WARMUP = 1152,
    parameter int LENW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [79:0]     key,
    input  logic [79:0]     iv,
    input  logic [LENW-1:0] len,
    input  logic            fifo_full,
    output logic [7:0]      dout,
    output logic            write,
    output logic            busy,
    output logic            done
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN
    } fsm_t;

    fsm_t fsm;
    fsm_t fsm_nx;

    // s_i lives at st[i-1]
    logic [287:0]    st;
    logic [287:0]    st_nx;
    logic [287:0]    st_init;
    logic [WCW-1:0]  wcnt;
    logic [LENW-1:0] bcnt;
    logic [LENW-1:0] len_q;
    logic [2:0]      bitcnt;
    logic [7:0]      pack;
    logic [7:0]      pack_nx;
    logic            pend;

    logic t1;
    logic t2;
    logic t3;
    logic z;
    logic n1;
    logic n2;
    logic n3;

    logic advance;
    logic last_byte;
    logic load;
    logic done_nx;

    // One Trivium round over the current state.
    always_comb begin
        t1 = st[65] ^ st[92];
        t2 = st[161] ^ st[176];
        t3 = st[242] ^ st[287];
        z  = t1 ^ t2 ^ t3;
        n1 = t1 ^ (st[90] & st[91]) ^ st[170];
        n2 = t2 ^ (st[174] & st[175]) ^ st[263];
        n3 = t3 ^ (st[285] & st[286]) ^ st[68];
        st_nx = {st[286:177], n2,
                 st[175:93], n1,
                 st[91:0], n3};
    end

    assign st_init = {3'b111, 108'd0, 4'd0, iv, 13'd0, key};

    always_comb begin
        pack_nx         = pack;
        pack_nx[bitcnt] = z;
    end

    // A full FIFO only freezes the generator when a byte is waiting.
    assign write     = pend & ~fifo_full;
    assign advance   = ~(pend & fifo_full);
    assign last_byte = write && (len_q != '0) &&
                       (bcnt + LENW'(1) == len_q);
    assign busy      = (fsm != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_nx;
        end
    end

    always_comb begin
        fsm_nx  = fsm;
        load    = 1'b0;
        done_nx = 1'b0;
        unique case (fsm)
            S_IDLE: begin
                if (!stop && start) begin
                    fsm_nx = S_WARM;
                    load   = 1'b1;
                end
            end
            S_WARM: begin
                if (stop) begin
                    fsm_nx = S_IDLE;
                end else if (wcnt == WCW'(WARMUP - 1)) begin
                    fsm_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    fsm_nx = S_IDLE;
                end else if (last_byte) begin
                    fsm_nx  = S_IDLE;
                    done_nx = 1'b1;
                end
            end
            default: begin
                fsm_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st     <= '0;
            wcnt   <= '0;
            bcnt   <= '0;
            len_q  <= '0;
            bitcnt <= '0;
            pack   <= '0;
            pend   <= 1'b0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_nx;
            if (load) begin
                st     <= st_init;
                len_q  <= len;
                wcnt   <= '0;
                bcnt   <= '0;
                bitcnt <= '0;
                pack   <= '0;
                pend   <= 1'b0;
            end else if (fsm_nx == S_IDLE) begin
                // Partial bytes and any unsent byte are dropped.
                pend   <= 1'b0;
                bitcnt <= '0;
                pack   <= '0;
            end else if (fsm == S_WARM) begin
                st   <= st_nx;
                wcnt <= wcnt + WCW'(1);
            end else if (fsm == S_RUN) begin
                if (write) begin
                    bcnt <= bcnt + LENW'(1);
                    pend <= 1'b0;
                end
                if (advance) begin
                    st     <= st_nx;
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        dout <= pack_nx;
                        pack <= '0;
                        pend <= 1'b1;
                    end else begin
                        pack <= pack_nx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_trivium_keygen.sv
// Self-checking bench for trivium_keygen.
// Keystream compared against a bit-array software model.
module tb_trivium_keygen;

    localparam int LENW = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic            stop;
    logic [79:0]     key;
    logic [79:0]     iv;
    logic [LENW-1:0] len;
    logic            fifo_full;
    logic [7:0]      dout;
    logic            write;
    logic            busy;
    logic            done;

    int errors;
    int checks;

    logic [7:0] exp_q[$];
    logic [7:0] got_b[$];
    int         got_c[$];
    int         done_c[$];
    int         busy_low;
    int         win_bad;

    trivium_keygen #(
        .WARMUP(1152),
        .LENW(LENW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .key(key),
        .iv(iv),
        .len(len),
        .fifo_full(fifo_full),
        .dout(dout),
        .write(write),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference keystream: Trivium on s[1..288] exactly as written
    // in the algorithm, first 1152 outputs discarded, LSB-first bytes.
    function automatic void gen(input logic [79:0] k,
                                input logic [79:0] v,
                                input int n);
        bit s[1:288];
        bit a;
        bit b;
        bit c;
        bit zz;
        logic [7:0] cur;
        int idx;
        exp_q.delete();
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) s[i] = k[i-1];
        for (int i = 1; i <= 80; i++) s[93+i] = v[i-1];
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        cur = 8'h00;
        for (int r = 0; r < 1152 + 8 * n; r++) begin
            a  = s[66] ^ s[93];
            b  = s[162] ^ s[177];
            c  = s[243] ^ s[288];
            zz = a ^ b ^ c;
            a  = a ^ (s[91] & s[92]) ^ s[171];
            b  = b ^ (s[175] & s[176]) ^ s[264];
            c  = c ^ (s[286] & s[287]) ^ s[69];
            for (int i = 93; i > 1; i--) s[i] = s[i-1];
            s[1] = c;
            for (int i = 177; i > 94; i--) s[i] = s[i-1];
            s[94] = a;
            for (int i = 288; i > 178; i--) s[i] = s[i-1];
            s[178] = b;
            if (r >= 1152) begin
                idx = (r - 1152) % 8;
                cur[idx] = zz;
                if (idx == 7) begin
                    exp_q.push_back(cur);
                    cur = 8'h00;
                end
            end
        end
    endfunction

    function automatic logic [79:0] rnd80();
        logic [79:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[79:64] = 16'($urandom());
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start; returns one step after the load edge (cycle 0).
    task automatic start_run(input logic [79:0] k,
                             input logic [79:0] v,
                             input logic [LENW-1:0] l);
        key   = k;
        iv    = v;
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Records write/done activity per cycle index for up to maxc cycles.
    task automatic collect(input int maxc, input int nstop,
                           input int fs, input int fl,
                           input logic [7:0] wexp,
                           input bit rnd_full, input bit rnd_start);
        got_b.delete();
        got_c.delete();
        done_c.delete();
        busy_low = -1;
        win_bad  = 0;
        for (int k = 0; k < maxc; k++) begin
            if (rnd_full)
                fifo_full = ($urandom_range(0, 3) == 0);
            else
                fifo_full = (fs >= 0 && k >= fs && k < fs + fl);
            start = rnd_start && ($urandom_range(0, 15) == 0);
            #1;
            if (write) begin
                got_b.push_back(dout);
                got_c.push_back(k);
            end
            if (done) done_c.push_back(k);
            if (!busy && busy_low < 0) busy_low = k;
            if (!rnd_full && fs >= 0 && k >= fs && k < fs + fl)
                if (write || dout !== wexp) win_bad++;
            if (nstop > 0 && got_b.size() >= nstop) break;
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic cmp_bytes(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= got_b.size() || i >= exp_q.size()) begin
                errors++;
                $display("FAIL %s byte %0d: missing", nm, i);
            end else if (got_b[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s byte %0d: got %h expected %h",
                         nm, i, got_b[i], exp_q[i]);
            end
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int ex);
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, ex);
        end
    endtask

    task automatic test_reset();
        int bad;
        #3;
        cmp_int("reset write", int'(write), 0);
        cmp_int("reset busy", int'(busy), 0);
        cmp_int("reset done", int'(done), 0);
        cmp_int("reset dout", int'(dout), 0);
        rst = 1'b1;
        step();
        fifo_full = 1'b1;
        start_run(rnd80(), rnd80(), 16'd5);
        repeat (1160) step();
        fifo_full = 1'b0;
        #1;
        cmp_int("pre-reset write", int'(write), 1);
        rst = 1'b0;
        #1;
        cmp_int("async write", int'(write), 0);
        cmp_int("async busy", int'(busy), 0);
        cmp_int("async done", int'(done), 0);
        cmp_int("async dout", int'(dout), 0);
        #1;
        rst = 1'b1;
        bad = 0;
        repeat (40) begin
            step();
            if (write || busy || done) bad++;
        end
        cmp_int("post-release activity", bad, 0);
    endtask

    task automatic test_warmup_latency();
        gen(80'd0, 80'd0, 1);
        start_run(80'd0, 80'd0, 16'd1);
        collect(1175, 0, -1, 0, 8'h00, 1'b0, 1'b0);
        cmp_int("lat writes", got_c.size(), 1);
        if (got_c.size() > 0) cmp_int("lat first write", got_c[0], 1160);
        cmp_bytes("lat", 1);
        cmp_int("lat dones", done_c.size(), 1);
        if (done_c.size() > 0) cmp_int("lat done cycle", done_c[0], 1161);
        cmp_int("lat busy low", busy_low, 1161);
    endtask

    task automatic test_throughput();
        logic [79:0] k;
        logic [79:0] v;
        k = rnd80();
        v = rnd80();
        gen(k, v, 4);
        start_run(k, v, 16'd4);
        collect(1200, 0, -1, 0, 8'h00, 1'b0, 1'b0);
        cmp_int("thr writes", got_c.size(), 4);
        for (int i = 0; i < got_c.size() && i < 4; i++)
            cmp_int("thr write cycle", got_c[i], 1160 + 8 * i);
        cmp_bytes("thr", 4);
        cmp_int("thr dones", done_c.size(), 1);
        if (done_c.size() > 0) cmp_int("thr done cycle", done_c[0], 1185);
        cmp_int("thr busy low", busy_low, 1185);
    endtask

    task automatic test_back_pressure();
        logic [79:0] k;
        logic [79:0] v;
        int exc[3];
        exc = '{1160, 1188, 1196};
        k = rnd80();
        v = rnd80();
        gen(k, v, 3);
        start_run(k, v, 16'd3);
        collect(1220, 0, 1168, 20, exp_q[1], 1'b0, 1'b0);
        cmp_int("bp writes", got_c.size(), 3);
        for (int i = 0; i < got_c.size() && i < 3; i++)
            cmp_int("bp write cycle", got_c[i], exc[i]);
        cmp_int("bp window", win_bad, 0);
        cmp_bytes("bp", 3);
        cmp_int("bp dones", done_c.size(), 1);
        if (done_c.size() > 0) cmp_int("bp done cycle", done_c[0], 1197);
    endtask

    task automatic test_stop_restart();
        logic [79:0] k;
        logic [79:0] v;
        k = rnd80();
        v = rnd80();
        gen(k, v, 2);
        start_run(rnd80(), rnd80(), 16'd2);
        repeat (500) step();
        cmp_int("stop busy before", int'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        cmp_int("stop busy after", int'(busy), 0);
        collect(1200, 0, -1, 0, 8'h00, 1'b0, 1'b0);
        cmp_int("stop writes", got_c.size(), 0);
        cmp_int("stop dones", done_c.size(), 0);
        start_run(k, v, 16'd2);
        collect(1180, 0, -1, 0, 8'h00, 1'b0, 1'b0);
        cmp_int("restart writes", got_c.size(), 2);
        if (got_c.size() > 0) cmp_int("restart first", got_c[0], 1160);
        cmp_bytes("restart", 2);
        cmp_int("restart dones", done_c.size(), 1);
    endtask

    task automatic test_continuous();
        logic [79:0] k;
        logic [79:0] v;
        k = rnd80();
        v = rnd80();
        gen(k, v, 400);
        start_run(k, v, 16'd0);
        collect(9000, 400, -1, 0, 8'h00, 1'b1, 1'b1);
        cmp_int("cont writes", got_b.size(), 400);
        cmp_bytes("cont", 400);
        cmp_int("cont dones", done_c.size(), 0);
        cmp_int("cont busy low", busy_low, -1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        cmp_int("cont stop busy", int'(busy), 0);
        cmp_int("cont stop done", int'(done), 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        key       = '0;
        iv        = '0;
        len       = '0;
        fifo_full = 1'b0;
        test_reset();
        test_warmup_latency();
        test_throughput();
        test_back_pressure();
        test_stop_restart();
        test_continuous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
